// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank controller: command op encodings and FSM states.
package jk_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DRIVE  = 2'b01,
    S_SETTLE = 2'b10,
    S_CHECK  = 2'b11
  } jk_ctrl_state_t;

endpackage

// File: rtl/jk_expect_calc.sv
// Combinational expected-Q calculation for one JK bank command.
module jk_expect_calc
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] snapshot,
  input  logic             cnt_odd,
  output logic [WIDTH-1:0] expected
);

  always_comb begin
    expected = snapshot;
    case (op)
      OP_HOLD:   expected = snapshot;
      OP_RESET:  expected = snapshot & ~mask;
      OP_SET:    expected = snapshot | mask;
      OP_TOGGLE: expected = snapshot ^ (cnt_odd ? mask : '0);
      default:   expected = snapshot;
    endcase
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: drive J/K for N edges, settle, verify Q.
// Optional macro JK_CHECK_EN adds the CHECK state and the err comparator.
module jk_bank_ctrl
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] jk_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  jk_ctrl_state_t state, state_next;

  logic [CNT_W-1:0] eff_count;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] snap_r;
  logic             cnt_odd_r;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] expected_calc;
  logic             accept;
  logic             finish;
  logic             check_fail;

  assign eff_count = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);

  jk_expect_calc #(.WIDTH(WIDTH)) u_expect (
    .op       (op_r),
    .mask     (mask_r),
    .snapshot (snap_r),
    .cnt_odd  (cnt_odd_r),
    .expected (expected_calc)
  );

`ifdef JK_CHECK_EN
  assign finish     = (state == S_CHECK);
  assign check_fail = (jk_q != expected);
`else
  logic unused_expect;
  assign finish        = (state == S_SETTLE);
  assign check_fail    = 1'b0;
  assign unused_expect = ^expected;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          state_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (count_r == CNT_W'(1)) state_next = S_SETTLE;
      end
`ifdef JK_CHECK_EN
      S_SETTLE: state_next = S_CHECK;
      S_CHECK:  state_next = S_IDLE;
`else
      S_SETTLE: state_next = S_IDLE;
`endif
      default:  state_next = S_IDLE;
    endcase
  end

  // The expected value is derived from the latched command one edge after
  // accept; it is stable long before CHECK reads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= '0;
      op_r      <= OP_HOLD;
      mask_r    <= '0;
      snap_r    <= '0;
      cnt_odd_r <= 1'b0;
      expected  <= '0;
      jk_j      <= '0;
      jk_k      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        op_r      <= cmd_op;
        mask_r    <= cmd_mask;
        snap_r    <= jk_q;
        cnt_odd_r <= eff_count[0];
        count_r   <= eff_count;
        jk_j      <= cmd_op[1] ? cmd_mask : '0;
        jk_k      <= cmd_op[0] ? cmd_mask : '0;
      end else if (state == S_DRIVE) begin
        expected <= expected_calc;
        if (count_r == CNT_W'(1)) begin
          jk_j <= '0;
          jk_k <= '0;
        end else begin
          count_r <= count_r - CNT_W'(1);
        end
      end
      if (finish) begin
        done <= 1'b1;
        err  <= check_fail;
      end
    end
  end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Sequencing controller for a bank of WIDTH JK flip-flops (jk_ff instances outside this block).
- Accepts one command at a time over a valid/ready handshake: HOLD, RESET, SET or TOGGLE on a bit mask, applied for a programmable number of clock edges.
- Drives the bank's J/K vectors, reads back Q, checks it against the expected result, and reports done/err.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank.
- CNT_W, 8, width of the edge-count field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 HOLD, 01 RESET (K), 10 SET (J), 11 TOGGLE (J=K=1).
- cmd_mask  in  WIDTH  bits to drive; 0 bits get J=K=0.
- cmd_count  in  CNT_W  number of edges to drive; 0 is treated as 1.
- jk_j  out  WIDTH  J vector to the bank, registered.
- jk_k  out  WIDTH  K vector to the bank, registered.
- jk_q  in  WIDTH  Q vector from the bank.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse with done when Q != expected.

Behaviour:
- Reset: asynchronous, active-high.
  - While rst=1: state IDLE; jk_j=jk_k=0, busy=0, done=0, err=0, cmd_ready=0.
  - Internal counter, snapshot and expected registers clear to 0.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - cmd_ready=1 (and rst=0), busy=0.
  - Accept on the edge where cmd_valid & cmd_ready: latch op, mask, eff_count=max(cmd_count,1), and snapshot jk_q.
  - Compute expected from the snapshot:
    - HOLD: snapshot.
    - SET: snapshot | mask.
    - RESET: snapshot & ~mask.
    - TOGGLE: snapshot ^ (mask if eff_count odd, else 0).
  - Same edge: go to DRIVE; load jk_j/jk_k with the op pattern ANDed with mask.
- DRIVE:
  - busy=1, cmd_ready=0.
  - J/K held stable for eff_count cycles, so the bank sees the pattern on eff_count edges; counter decrements each edge.
  - On the edge where counter reaches 1: jk_j=jk_k=0, go to SETTLE.
- SETTLE: one cycle with J=K=0 (bank samples hold); go to CHECK.
- CHECK:
  - Compare jk_q to expected.
  - On exit edge: done=1, err=(jk_q!=expected), state IDLE.
  - done/err are registered, so they are visible in the first IDLE cycle; cmd_ready=1 in that same cycle.
- Latency:
  - done asserts eff_count+2 cycles after the accept edge.
  - Minimum accept-to-accept spacing is eff_count+3 cycles.
- cmd_valid while busy is ignored; there is no queuing, and the command must be held until accepted.
- mask=0: full sequence runs with J=K=0; expected=snapshot.
- Counter full-scale: cmd_count = 2^CNT_W-1 is legal; there is no wrap, because the counter only decrements to 1.
- Reset mid-operation (any state): immediate return to reset values; no done/err; the next command is accepted normally after release.

Optional Feature:
- Macro: JK_CHECK_EN.
- Defined: CHECK state present; err driven as above.
- Undefined:
  - CHECK state and comparator removed; err tied 0.
  - SETTLE exits directly to IDLE with the done pulse, so done asserts eff_count+1 cycles after accept.
  - The expected register is still computed but unused (may be optimised away).

Decomposition:
- Shared package jk_pkg:
  - op encoding constants OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE.
  - FSM state typedef jk_ctrl_state_t.
- Sub-module jk_expect_calc: purely combinational expected-Q calculation from (op, mask, snapshot, eff_count LSB), reused by the bench's reference model.

Test Plan (WIDTH=4, bank of four jk_ff attached):
- Reset: rst=1 for 3 cycles mid-stream -> jk_j=jk_k=0000, busy=0, done=0, cmd_ready=0; after release cmd_ready=1.
- SET: Q=0000, op=10, mask=0101, count=1 -> jk_j=0101 for 1 cycle; Q=0101; done 3 cycles after accept; err=0.
- TOGGLE: Q=0101, op=11, mask=1111, count=3 -> jk_j=jk_k=1111 for 3 cycles; Q=1010; done 5 cycles after accept; err=0.
- RESET with count=0 and busy check:
  - From Q=1010, op=01, mask=1100, count=0 -> driven 1 cycle; Q=0010; done 3 cycles after accept.
  - A second cmd_valid asserted during DRIVE is not accepted until cmd_ready returns.
- Error: bench forces jk_q[0] stuck at 0; SET mask=0001, count=2 -> done=1 with err=1 in the same cycle. With JK_CHECK_EN undefined, err=0 and done arrives 1 cycle earlier.
- Reset mid-DRIVE: TOGGLE mask=1111 count=5, assert rst after 2 cycles -> jk_j/jk_k drop to 0000 asynchronously; no done pulse; post-release SET mask=0001 count=1 completes normally.
